// File: rtl/trace_frame_ctrl_pkg.sv
// Shared types and constants for the trace pin front-end controller.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECONF = 2'd1,
        ST_HUNT   = 2'd2,
        ST_LOCKED = 2'd3
    } trace_state_t;

    localparam int FRAME_WORDS = 8;
    localparam int WORD_BITS   = 16;
    localparam int FRAME_BITS  = FRAME_WORDS * WORD_BITS;

    localparam logic [1:0] WIDTH_1B = 2'd1;
    localparam logic [1:0] WIDTH_2B = 2'd2;
    localparam logic [1:0] WIDTH_4B = 2'd3;

endpackage

// File: rtl/trace_frame_ctrl_fifo.sv
// Synchronous frame FIFO with a registered show-ahead head.
// A pushed frame becomes visible at the head one cycle after it is written.
module trace_frame_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FRAME_BITS
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      rd_ptr_next;
    logic             push_ok;
    logic             head_valid_reg;
    logic [WIDTH-1:0] head_data_reg;

    assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    // A pop frees the slot the push lands in, so full+pop still accepts.
    assign push_ok     = push && (!full || pop);
    assign rd_ptr_next = pop ? rd_ptr_reg + (AW+1)'(1) : rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Head is computed against the pre-push write pointer, so a slot being
    // written this cycle is never presented before it holds data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            head_valid_reg <= 1'b0;
            head_data_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            rd_ptr_reg     <= rd_ptr_next;
            head_valid_reg <= (wr_ptr_reg != rd_ptr_next);
            head_data_reg  <= mem[rd_ptr_next[AW-1:0]];
        end
    end

    assign head_valid = head_valid_reg;
    assign head_data  = head_data_reg;

endmodule

// File: rtl/trace_frame_ctrl.sv
// Trace front-end sequencer: width reconfiguration under reset, sync lock
// tracking with timeout, 8-word frame assembly and a frame FIFO towards the decoder.
module trace_frame_ctrl
    import trace_pkg::*;
#(
    parameter int FIFO_FRAMES   = 4,
    parameter int SYNC_TIMEOUT  = 65535,
    parameter int RECONF_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [1:0]            cfgWidth,
    input  logic                  cfgWrite,
    output logic                  tifRst,
    output logic [1:0]            tifWidth,
    input  logic                  WdAvail,
    input  logic [WORD_BITS-1:0]  PacketWd,
    input  logic                  PacketReset,
    input  logic                  sync,
    output logic [FRAME_BITS-1:0] frameOut,
    output logic                  frameValid,
    input  logic                  frameReady,
    output logic                  locked,
    output logic [15:0]           droppedFrames
);

    localparam int TW = $clog2(SYNC_TIMEOUT + 1);
    localparam int CW = (RECONF_CYCLES > 1) ? $clog2(RECONF_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(SYNC_TIMEOUT);
    localparam logic [CW-1:0] RECONF_LAST = CW'(RECONF_CYCLES - 1);

    trace_state_t    state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [TW-1:0]   timer_reg;
    logic [TW-1:0]   timer_inc;
    logic [2:0]      idx_reg;
    logic [1:0]      pend_reg;
    logic [1:0]      width_reg;
    logic            tif_rst_reg, tif_rst_next;
    logic            locked_reg, locked_next;
    logic [15:0]     drop_reg;

    logic            rules_en;
    logic            reconf_entry;
    logic            clear;
    logic            word_we;
    logic            commit;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop_req;
    logic [FRAME_BITS-1:0] frame_data;

    assign timer_inc = timer_reg + TW'(1);
    // Per-state rules only run when neither enable=0 nor a cfgWrite override applies.
    assign rules_en  = enable && !(cfgWrite && state_reg != ST_IDLE);
    assign clear     = rules_en && state_reg == ST_LOCKED && (sync || PacketReset);
    assign word_we   = rules_en && state_reg == ST_LOCKED && !clear && WdAvail;
    assign commit    = word_we && idx_reg == 3'd7;
    assign pop_req   = frameValid && frameReady && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = ST_IDLE;
        end else if (cfgWrite && state_reg != ST_IDLE) begin
            state_next = ST_RECONF;
        end else begin
            case (state_reg)
                ST_IDLE:   state_next = ST_RECONF;
                ST_RECONF: if (cnt_reg == RECONF_LAST) state_next = ST_HUNT;
                ST_HUNT:   if (sync) state_next = ST_LOCKED;
                ST_LOCKED: if (!sync && !PacketReset && timer_inc == TIMEOUT_VAL) state_next = ST_HUNT;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tif_rst_next = (state_next == ST_IDLE) || (state_next == ST_RECONF);
        locked_next  = (state_next == ST_LOCKED);
        reconf_entry = (state_next == ST_RECONF) && (state_reg != ST_RECONF || cfgWrite);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tif_rst_reg <= 1'b1;
            locked_reg  <= 1'b0;
            width_reg   <= WIDTH_4B;
            pend_reg    <= WIDTH_4B;
            cnt_reg     <= '0;
            timer_reg   <= '0;
            idx_reg     <= '0;
            drop_reg    <= '0;
        end else begin
            tif_rst_reg <= tif_rst_next;
            locked_reg  <= locked_next;
            if (cfgWrite) begin
                pend_reg <= cfgWidth;
            end
            // A write arriving with the entry itself must take effect immediately.
            if (reconf_entry) begin
                width_reg <= cfgWrite ? cfgWidth : pend_reg;
                cnt_reg   <= '0;
            end else if (state_reg == ST_RECONF) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            if (state_reg == ST_LOCKED && state_next == ST_LOCKED && !clear) begin
                timer_reg <= timer_inc;
            end else begin
                timer_reg <= '0;
            end
            if (state_next != ST_LOCKED || clear) begin
                idx_reg <= '0;
            end else if (word_we) begin
                idx_reg <= idx_reg + 3'd1;
            end
            if (commit && fifo_full && !pop_req && drop_reg != 16'hFFFF) begin
                drop_reg <= drop_reg + 16'd1;
            end
        end
    end

    // Words 0..6 are held in registers; word 7 goes straight from the pins into the FIFO.
    genvar gi;
    generate
        for (gi = 0; gi < FRAME_WORDS - 1; gi++) begin : g_asm
            logic [WORD_BITS-1:0] word_reg;
            always_ff @(posedge clk) begin
                if (word_we && idx_reg == 3'(gi)) begin
                    word_reg <= PacketWd;
                end
            end
            assign frame_data[gi*WORD_BITS +: WORD_BITS] = word_reg;
        end
    endgenerate
    assign frame_data[FRAME_BITS-1 -: WORD_BITS] = PacketWd;

    trace_frame_fifo #(
        .DEPTH (FIFO_FRAMES),
        .WIDTH (FRAME_BITS)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (commit),
        .push_data  (frame_data),
        .pop        (pop_req),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_valid (frameValid),
        .head_data  (frameOut)
    );

    assign tifRst        = tif_rst_reg;
    assign tifWidth      = width_reg;
    assign locked        = locked_reg;
    assign droppedFrames = drop_reg;

endmodule
